// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch requester and a data requester.
// Data normally wins; a starvation counter forces fetch through, and a wait counter aborts stalls.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned WAIT_MAX   = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [AW-1:0]     if_addr,
   output logic [DW-1:0]     if_rdata,
   output logic              if_done,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [AW-1:0]     dm_addr,
   input  logic [DW-1:0]     dm_wdata,
   input  logic [DW/8-1:0]   dm_be,
   output logic [DW-1:0]     dm_rdata,
   output logic              dm_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic [DW/8-1:0]   mem_be,
   input  logic              mem_ack,
   input  logic [DW-1:0]     mem_rdata,
   output logic              err,
   output logic              busy
);
   localparam int unsigned BW     = DW / 8;
   localparam int unsigned SW_MIN = $clog2(STARVE_MAX + 1);
   localparam int unsigned SW     = (SW_MIN < 3) ? 3 : SW_MIN;
   localparam int unsigned WW     = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic            we_q;
   logic [BW-1:0]   be_q;
   logic [DW-1:0]   if_rdata_q, dm_rdata_q;
   logic            if_done_q, dm_done_q, err_q;
   logic [SW-1:0]   starve_q;
   logic [WW-1:0]   wait_q;

   logic            active, if_ok, dm_ok, starved, timeout;
   logic            grant_if, grant_dm, finish;

   // A requester whose done is high is masked so a held request is not re-granted.
   assign if_ok    = if_req & ~if_done_q;
   assign dm_ok    = dm_req & ~dm_done_q;
   assign starved  = (starve_q == SW'(STARVE_MAX));
   assign timeout  = (wait_q == WW'(WAIT_MAX - 1)) & ~mem_ack;
   assign grant_if = (state_q == StIdle) & (state_d == StFetch);
   assign grant_dm = (state_q == StIdle) & (state_d == StData);
   assign finish   = active & (mem_ack | timeout);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (if_ok && (starved || !dm_ok)) begin
               state_d = StFetch;
            end else if (dm_ok) begin
               state_d = StData;
            end
         end
         StFetch, StData: begin
            if (mem_ack || timeout) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      active    = (state_q != StIdle);
      busy      = active;
      mem_req   = active;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_be    = be_q;
      if_rdata  = if_rdata_q;
      dm_rdata  = dm_rdata_q;
      if_done   = if_done_q;
      dm_done   = dm_done_q;
      err       = err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         be_q       <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         if_done_q  <= 1'b0;
         dm_done_q  <= 1'b0;
         err_q      <= 1'b0;
         starve_q   <= '0;
         wait_q     <= '0;
      end else begin
         if_done_q <= finish & (state_q == StFetch);
         dm_done_q <= finish & (state_q == StData);
         err_q     <= active & timeout;

         if (grant_if) begin
            addr_q   <= if_addr;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '1;
            starve_q <= '0;
         end else if (grant_dm) begin
            addr_q  <= dm_addr;
            we_q    <= dm_we;
            wdata_q <= dm_wdata;
            be_q    <= dm_be;
            if (if_req && !starved) begin
               starve_q <= starve_q + SW'(1);
            end
         end

         if (grant_if || grant_dm) begin
            wait_q <= '0;
         end else if (active && !mem_ack) begin
            wait_q <= wait_q + WW'(1);
         end

         if (active && mem_ack) begin
            if (state_q == StFetch) begin
               if_rdata_q <= mem_rdata;
            end else begin
               dm_rdata_q <= mem_rdata;
            end
         end
      end
   end
endmodule
